// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with stalling memories.
// Optional retire counter output enabled by defining MCU_RETIRE_COUNT_EN.
//
// state     | meaning
// FETCH     | request instruction, latch op/funct on inst_ready
// DECODE    | flag illegal opcodes, otherwise proceed
// EXECUTE   | drive ALU op and operand select for the class
// MEM       | data memory access for load/store, stalls on mem_ready
// WRITEBACK | register file write and retire
module multicycle_control_unit #(
  parameter int OP_W    = 2,
  parameter int FUNCT_W = 2,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               inst_ready,
  input  logic               mem_ready,
  output logic               inst_req,
  output logic               irWrite,
  output logic               pcWrite,
  output logic               mem_req,
  output logic               memWrite,
  output logic               regWrite,
  output logic               useImmediate,
  output logic               useLoad,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
`ifdef MCU_RETIRE_COUNT_EN
  output logic [CNT_W-1:0]   retired_count,
`endif
  output logic               instr_done
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  // Opcodes compared one bit wider so "op >= 4" is well defined for any OP_W.
  localparam logic [OP_W:0] OP_ITYPE = (OP_W+1)'(1);
  localparam logic [OP_W:0] OP_LOAD  = (OP_W+1)'(2);
  localparam logic [OP_W:0] OP_STORE = (OP_W+1)'(3);

  state_t               state, nextState;
  logic [OP_W-1:0]      opQ;
  logic [FUNCT_W-1:0]   functQ;
  logic [OP_W:0]        opExt;
  logic                 isIllegal, isItype, isLoad, isStore;
  logic [ALUOP_W-1:0]   classAluop;
  logic                 classUseImm;

  assign opExt     = {1'b0, opQ};
  assign isIllegal = opExt > OP_STORE;
  assign isItype   = opExt == OP_ITYPE;
  assign isLoad    = opExt == OP_LOAD;
  assign isStore   = opExt == OP_STORE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      opQ    <= '0;
      functQ <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH && inst_ready) begin
        opQ    <= op;
        functQ <= funct;
      end
    end
  end

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:     nextState = inst_ready ? DECODE : FETCH;
      DECODE:    nextState = isIllegal ? FETCH : EXECUTE;
      EXECUTE:   nextState = (isLoad || isStore) ? MEM : WRITEBACK;
      MEM: begin
        if (!mem_ready)  nextState = MEM;
        else if (isLoad) nextState = WRITEBACK;
        else             nextState = FETCH;
      end
      WRITEBACK: nextState = FETCH;
      default:   nextState = FETCH;
    endcase
  end

  // Memory ops compute base+immediate with add; R/I pass funct straight through.
  always_comb begin
    if (isLoad || isStore) begin
      classAluop  = '0;
      classUseImm = 1'b1;
    end else begin
      classAluop  = ALUOP_W'(functQ);
      classUseImm = isItype;
    end
  end

  always_comb begin
    inst_req     = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    mem_req      = 1'b0;
    memWrite     = 1'b0;
    regWrite     = 1'b0;
    useImmediate = 1'b0;
    useLoad      = 1'b0;
    aluop        = '0;
    illegal_op   = 1'b0;
    instr_done   = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          inst_req = 1'b1;
          irWrite  = inst_ready;
          pcWrite  = inst_ready;
        end
        DECODE:  illegal_op = isIllegal;
        EXECUTE: begin
          aluop        = classAluop;
          useImmediate = classUseImm;
        end
        MEM: begin
          mem_req      = 1'b1;
          useImmediate = 1'b1;
          memWrite     = isStore;
          instr_done   = isStore && mem_ready;
        end
        WRITEBACK: begin
          regWrite     = 1'b1;
          instr_done   = 1'b1;
          useLoad      = isLoad;
          aluop        = classAluop;
          useImmediate = classUseImm;
        end
        default: ;
      endcase
    end
  end

`ifdef MCU_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)           retired_count <= '0;
    else if (instr_done) retired_count <= retired_count + CNT_W'(1);
  end
`else
  localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: random instructions with random fetch/memory stalls, checked per retired
// instruction against counts and latency derived from the instruction class.
module tb_multicycle_control_unit;
  localparam int OP_W = 3, FUNCT_W = 2, ALUOP_W = 3, CNT_W = 2;
  localparam int N_INSTR = 200;

  logic clk = 1'b0, reset = 1'b1;
  logic [OP_W-1:0] op = '0;
  logic [FUNCT_W-1:0] funct = '0;
  logic inst_ready = 1'b0, mem_ready = 1'b0;
  logic inst_req, irWrite, pcWrite, mem_req, memWrite, regWrite, useImmediate, useLoad;
  logic [ALUOP_W-1:0] aluop;
  logic illegal_op, instr_done;
`ifdef MCU_RETIRE_COUNT_EN
  logic [CNT_W-1:0] retired_count;
`endif

  multicycle_control_unit #(.OP_W(OP_W), .FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .inst_ready(inst_ready), .mem_ready(mem_ready),
    .inst_req(inst_req), .irWrite(irWrite), .pcWrite(pcWrite), .mem_req(mem_req), .memWrite(memWrite),
    .regWrite(regWrite), .useImmediate(useImmediate), .useLoad(useLoad), .aluop(aluop),
    .illegal_op(illegal_op),
`ifdef MCU_RETIRE_COUNT_EN
    .retired_count(retired_count),
`endif
    .instr_done(instr_done));

  always #5 clk = ~clk;

  typedef struct {
    int lat; int irw; int pcw; int regw; int memreq; int memw; int useld; int ill; int done;
    int alu; int imm; bit chkAlu;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0, cycles = 0, issued = 0;
  bit monEn = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL watchdog: got %0d cycles expected below 20000", cycles);
      $fatal(1, "timeout");
    end
  end

  // Monitor: accumulate per-instruction activity, compare on each retire/illegal pulse.
  exp_t acc = '{default: 0};
  logic [CNT_W-1:0] expCnt = '0;
  always @(negedge clk) begin
    if (monEn) begin
      exp_t e;
      acc.lat++;
      acc.irw += int'(irWrite); acc.pcw += int'(pcWrite); acc.regw += int'(regWrite);
      acc.memreq += int'(mem_req); acc.memw += int'(memWrite); acc.useld += int'(useLoad);
      acc.ill += int'(illegal_op); acc.done += int'(instr_done);
      if (regWrite || mem_req) begin
        acc.alu = int'(aluop); acc.imm = int'(useImmediate);
      end
      check("irWrite_regWrite_exclusive", int'(irWrite && regWrite), 0);
      if (instr_done || illegal_op) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency", acc.lat, e.lat);
          check("irWrite_cycles", acc.irw, e.irw);
          check("pcWrite_cycles", acc.pcw, e.pcw);
          check("regWrite_cycles", acc.regw, e.regw);
          check("mem_req_cycles", acc.memreq, e.memreq);
          check("memWrite_cycles", acc.memw, e.memw);
          check("useLoad_cycles", acc.useld, e.useld);
          check("illegal_op_pulses", acc.ill, e.ill);
          check("instr_done_pulses", acc.done, e.done);
          if (e.chkAlu) begin
            check("aluop", acc.alu, e.alu);
            check("useImmediate", acc.imm, e.imm);
          end
        end
`ifdef MCU_RETIRE_COUNT_EN
        check("retired_count", int'(retired_count), int'(expCnt));
        if (instr_done) expCnt = expCnt + 1'b1;
`endif
        acc = '{default: 0};
      end
    end
  end

  // Driver state for the instruction currently being fetched / in flight.
  int fw, mw, curFw, curMw;
  logic [OP_W-1:0] curOp;
  logic [FUNCT_W-1:0] curFunct;

  task automatic newInstr();
    curOp    = ($urandom_range(0, 3) == 0) ? OP_W'($urandom_range(4, 7)) : OP_W'($urandom_range(0, 3));
    curFunct = FUNCT_W'($urandom_range(0, 3));
    curFw    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
    curMw    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
    fw       = curFw;
  endtask

  // Reference: expected activity from the instruction class and chosen stall counts.
  function automatic exp_t model(input int o, input int f, input int wf, input int wm);
    exp_t e = '{default: 0};
    e.irw = 1; e.pcw = 1;
    if (o >= 4) begin
      e.ill = 1; e.lat = wf + 2;
    end else begin
      e.done = 1; e.chkAlu = 1'b1;
      case (o)
        0, 1: begin e.regw = 1; e.lat = wf + 4; e.alu = f; e.imm = (o == 1) ? 1 : 0; end
        2: begin e.regw = 1; e.memreq = wm + 1; e.useld = 1; e.lat = wf + wm + 5; e.imm = 1; end
        default: begin e.memreq = wm + 1; e.memw = wm + 1; e.lat = wf + wm + 4; e.imm = 1; end
      endcase
    end
    return e;
  endfunction

  task automatic driveCycle();
    if (inst_req) begin
      if (fw > 0) begin
        inst_ready = 1'b0; fw--; op = OP_W'($urandom);
      end else begin
        inst_ready = 1'b1; op = curOp; funct = curFunct;
        sb.push_back(model(int'(curOp), int'(curFunct), curFw, curMw));
        mw = curMw; issued++;
        newInstr();
      end
    end else begin
      inst_ready = 1'($urandom); op = OP_W'($urandom);
    end
    if (mem_req) begin
      if (mw > 0) begin mem_ready = 1'b0; mw--; end
      else mem_ready = 1'b1;
    end else begin
      mem_ready = 1'($urandom);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs_zero",
            int'({inst_req, irWrite, pcWrite, mem_req, memWrite, regWrite, useImmediate, useLoad,
                  aluop, illegal_op, instr_done}), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; inst_ready = 1'b0; mem_ready = 1'b0;
    #1;
    check("release_inst_req", int'(inst_req), 1);
    check("release_irWrite", int'(irWrite), 0);
`ifdef MCU_RETIRE_COUNT_EN
    check("release_retired_count", int'(retired_count), 0);
`endif
    monEn = 1'b1;
    newInstr();
    while (issued < N_INSTR) begin
      driveCycle();
      @(posedge clk); #1;
    end
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      driveCycle();
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    monEn = 1'b0;

    // Reset during a store's MEM state aborts it.
    n = 0;
    while (!inst_req && n < 20) begin inst_ready = 1'b0; mem_ready = 1'b0; @(posedge clk); #1; n++; end
    inst_ready = 1'b1; op = OP_W'(3); funct = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
    check("abort_reached_mem", int'(mem_req), 1);
    check("abort_memWrite_before", int'(memWrite), 1);
    reset = 1'b1; #1;
    check("abort_memWrite_in_reset", int'(memWrite), 0);
    check("abort_done_in_reset", int'(instr_done), 0);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("abort_fetch_after", int'(inst_req), 1);
    check("abort_no_regWrite", int'(regWrite), 0);
`ifdef MCU_RETIRE_COUNT_EN
    check("abort_retired_count", int'(retired_count), 0);
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
